uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_tx write port (tx_we_i/din_i/full_o) between NUM_REQ byte-stream requesters. It grants one requester at a time and holds the grant for a whole packet, or until MAX_BURST bytes have been sent. It forwards bytes into the UART TX FIFO with full-based backpressure. It sits between on-chip clients (debug console, logger, host-interface core) and uart_tx.

Parameters:
NUM_REQ, 4, number of requesters; must be >= 2.
DATA_WIDTH, 8, byte width; must match uart_tx DATA_WIDTH.
MAX_BURST, 16, maximum bytes per grant before forced release; power of two, >= 2.

Ports:
clk_i  input  1  clock.
rst_ni  input  1  reset, synchronous, active-low.
req_valid_i  input  NUM_REQ  per-requester byte valid.
req_data_i  input  NUM_REQ*DATA_WIDTH  flattened data; requester k at [k*DATA_WIDTH +: DATA_WIDTH].
req_last_i  input  NUM_REQ  marks the final byte of a packet.
req_ready_o  output  NUM_REQ  per-requester accept.
tx_full_i  input  1  from uart_tx full_o.
tx_we_o  output  1  to uart_tx tx_we_i.
tx_data_o  output  DATA_WIDTH  to uart_tx din_i.
grant_o  output  NUM_REQ  one-hot current grant; all-zero when idle.
busy_o  output  1  high whenever state != IDLE.

Behaviour:
- Reset: rst_ni sampled low at posedge gives state=IDLE, grant index g=0, rr_ptr=0, burst_cnt=0. All outputs are 0 the following cycle. Reset mid-packet aborts the packet; no partial-state carryover.
- States: IDLE, HDR (only with the optional feature), XFER.
- IDLE: if any req_valid_i is set, register g = first set bit scanning rr_ptr, rr_ptr+1, ..., wrapping NUM_REQ-1 to 0. Then go to XFER (or HDR). Arbitration latency is 1 cycle; no writes occur in IDLE.
- XFER datapath (combinational):
  - req_ready_o[g] = !tx_full_i; every other ready bit is 0.
  - tx_we_o = req_valid_i[g] & !tx_full_i.
  - tx_data_o = req_data_i[g]; tx_data_o is 0 when tx_we_o is low.
- A transfer is req_valid_i[g] & req_ready_o[g]. Each transfer increments burst_cnt, which is $clog2(MAX_BURST) bits wide.
- Release: on a transfer with req_last_i[g]=1, or with burst_cnt==MAX_BURST-1:
  - next state is IDLE and burst_cnt clears;
  - rr_ptr = (g==NUM_REQ-1) ? 0 : g+1 (explicit wrap, no power-of-two reliance).
- The granted requester dropping valid mid-packet does not release the grant; the arbiter waits indefinitely.
- tx_full_i high: no write and no ready; data is held by the requester. A byte is never lost or duplicated.
- Other requesters' valid/last/data are ignored while not granted.
- Throughput: 1 byte/cycle while granted and not full. Between grants there is 1 dead IDLE cycle.
- grant_o = one-hot(g) in HDR/XFER, 0 in IDLE. busy_o = (state != IDLE).

Optional Feature:
UART_TX_ARB_HDR_EN
- Defined:
  - IDLE goes to HDR after the grant.
  - HDR writes one header byte {1'b1, g zero-extended to DATA_WIDTH-1 bits} when !tx_full_i, then moves to XFER.
  - req_ready_o is all-zero in HDR.
  - The header does not count toward MAX_BURST.
  - A forced MAX_BURST release followed by a re-grant emits a new header.
- Undefined: the HDR state and its logic are absent, and IDLE goes directly to XFER.

Decomposition:
- Package uart_arb_pkg:
  - state_t enum {IDLE, HDR, XFER}, logic [1:0];
  - HDR_MARK constant (the header MSB flag).
- Sub-module rr_pick: combinational priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: found flag, index.
  - Instantiated once.

Test Plan:
1. Req0 sends 0x41,0x42,0x43 (last on 0x43), tx_full_i=0: grant_o=0001 one cycle after valid. tx_we_o high on 3 consecutive cycles with data 0x41,0x42,0x43. Then grant_o=0, busy_o=0.
2. All four requesters valid with 1-byte packets (last=1) after reset: grant order 0,1,2,3,0; each grant separated by 1 IDLE cycle.
3. Req1 mid-packet with tx_full_i held high 5 cycles: req_ready_o=0 and tx_we_o=0 for those 5 cycles, grant_o stays 0010. Bytes resume in order with none lost.
4. Req2 streams 20 bytes with no last, req3 valid: exactly 16 writes, release, req3 granted, then req2 regranted for the remaining 4 bytes.
5. rst_ni low at a posedge during XFER on req3: next cycle busy_o=0, grant_o=0, tx_we_o=0. The next arbitration starts scanning from req0.
6. With UART_TX_ARB_HDR_EN and DATA_WIDTH=8, req1 sends 0x55 with last=1: writes 0x81, then 0x55. req_ready_o[1] is low during the header cycle.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types for the uart_tx round-robin arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    XFER = 2'd2
  } state_t;

  // MSB flag that marks a header byte on the UART stream
  localparam logic HDR_MARK = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  int unsigned j;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      // explicit wrap so N need not be a power of two
      j = 32'(rr_ptr_i) + i;
      if (j >= N) j = j - N;
      if (!found_o && req_i[IW'(j)]) begin
        found_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx write port between NUM_REQ byte streams.
// Optional per-grant header byte enabled by defining UART_TX_ARB_HDR_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          tx_full_i,
  output logic                          tx_we_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST);

  state_t        state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          pick_found;
  logic [IW-1:0] pick_idx;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req_i    (req_valid_i),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      g_q         <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    req_ready_o = '0;
    tx_we_o     = 1'b0;
    tx_data_o   = '0;
    grant_o     = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          g_d = pick_idx;
`ifdef UART_TX_ARB_HDR_EN
          state_d = HDR;
`else
          state_d = XFER;
`endif
        end
      end
`ifdef UART_TX_ARB_HDR_EN
      HDR: begin
        grant_o[g_q] = 1'b1;
        if (!tx_full_i) begin
          tx_we_o   = 1'b1;
          tx_data_o = {HDR_MARK, (DATA_WIDTH-1)'(g_q)};
          state_d   = XFER;
        end
      end
`endif
      XFER: begin
        grant_o[g_q]     = 1'b1;
        req_ready_o[g_q] = !tx_full_i;
        if (req_valid_i[g_q] && !tx_full_i) begin
          tx_we_o     = 1'b1;
          tx_data_o   = req_data_i[g_q*DATA_WIDTH +: DATA_WIDTH];
          burst_cnt_d = burst_cnt_q + BW'(1);
          // release on packet end or on the last byte of a full burst
          if (req_last_i[g_q] || burst_cnt_q == BW'(MAX_BURST-1)) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
            rr_ptr_d    = (g_q == IW'(NUM_REQ-1)) ? '0 : g_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter against a packet-level reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;
`ifdef UART_TX_ARB_HDR_EN
  localparam int HDRS = 1;
`else
  localparam int HDRS = 0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    req_valid_i, req_last_i, req_ready_o, grant_o;
  logic [N*DW-1:0] req_data_i;
  logic            tx_full_i, tx_we_o, busy_o;
  logic [DW-1:0]   tx_data_o;

  always #5 clk_i = ~clk_i;

  uart_tx_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_full_i   (tx_full_i),
    .tx_we_o     (tx_we_o),
    .tx_data_o   (tx_data_o),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef logic [DW:0] ent_t;      // {last, data}
  ent_t          q [N][$];
  logic [DW-1:0] wr_log [$];
  int            grant_log [$];
  int            wr_cnt;
  logic [N-1:0]  prev_grant;

  // reference model: owner -1 means idle
  int m_owner, m_ptr, m_sent;
  bit m_hdr;
  int valid_pct, full_pct;

  function automatic logic [DW-1:0] hdr_byte(input int r);
    return {1'b1, (DW-1)'(r)};
  endfunction

  task automatic add_pkt(input int r, input int len, input bit with_last, input int base);
    for (int i = 0; i < len; i++)
      q[r].push_back({(with_last && i == len-1), DW'(base + i)});
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    req_valid_i = '0;
    tx_full_i   = 1'b0;
    @(posedge clk_i); #1;
    rst_ni  = 1'b1;
    m_owner = -1; m_ptr = 0; m_sent = 0; m_hdr = 1'b0;
    for (int k = 0; k < N; k++) q[k].delete();
    wr_log.delete();
    grant_log.delete();
    wr_cnt     = 0;
    prev_grant = '0;
  endtask

  task automatic step();
    logic [N-1:0]  e_grant, e_ready;
    logic          e_we, e_busy, lst, found;
    logic [DW-1:0] e_data;
    int            c;
    for (int k = 0; k < N; k++) begin
      if (q[k].size() > 0 && $urandom_range(99) < valid_pct) begin
        req_valid_i[k]             = 1'b1;
        req_data_i[k*DW +: DW]     = q[k][0][DW-1:0];
        req_last_i[k]              = q[k][0][DW];
      end else begin
        req_valid_i[k]             = 1'b0;
        req_data_i[k*DW +: DW]     = DW'($urandom);
        req_last_i[k]              = 1'($urandom);
      end
    end
    tx_full_i = ($urandom_range(99) < full_pct);
    @(negedge clk_i);
    e_grant = '0; e_ready = '0; e_we = 1'b0; e_busy = 1'b0; e_data = '0;
    if (m_owner >= 0) begin
      e_busy  = 1'b1;
      e_grant = N'(1) << m_owner;
      if (m_hdr) begin
        e_we   = !tx_full_i;
        e_data = e_we ? hdr_byte(m_owner) : '0;
      end else begin
        e_ready = tx_full_i ? '0 : e_grant;
        e_we    = req_valid_i[m_owner] && !tx_full_i;
        e_data  = e_we ? q[m_owner][0][DW-1:0] : '0;
      end
    end
    check_eq("grant", 32'(grant_o), 32'(e_grant));
    check_eq("ready", 32'(req_ready_o), 32'(e_ready));
    check_eq("we", 32'(tx_we_o), 32'(e_we));
    check_eq("data", 32'(tx_data_o), 32'(e_data));
    check_eq("busy", 32'(busy_o), 32'(e_busy));
    if (tx_we_o === 1'b1) begin
      wr_log.push_back(tx_data_o);
      wr_cnt++;
    end
    if (grant_o != '0 && prev_grant == '0)
      for (int k = 0; k < N; k++) if (grant_o[k]) grant_log.push_back(k);
    prev_grant = grant_o;
    // advance model to the state after the coming edge
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && req_valid_i[c]) begin
          found = 1'b1; m_owner = c; m_sent = 0; m_hdr = (HDRS == 1);
        end
      end
    end else if (m_hdr) begin
      if (!tx_full_i) m_hdr = 1'b0;
    end else if (e_we) begin
      lst = q[m_owner][0][DW];
      void'(q[m_owner].pop_front());
      m_sent++;
      if (lst || m_sent == MB) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic check_bytes(input string tag, input logic [DW-1:0] exp [$]);
    check_eq({tag, "_len"}, 32'(wr_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check_eq(tag, (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  task automatic check_grants(input string tag, input int exp [$]);
    for (int i = 0; i < exp.size(); i++)
      check_eq(tag, (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  logic [DW-1:0] eb [$];
  int            eg [$];

  initial begin
    rst_ni = 1'b0; req_valid_i = '0; req_last_i = '0; req_data_i = '0; tx_full_i = 1'b0;
    valid_pct = 100; full_pct = 0;

    // single packet from req0
    do_reset();
    add_pkt(0, 3, 1'b1, 8'h41);
    repeat (7) step();
    eb.delete();
    if (HDRS == 1) eb.push_back(hdr_byte(0));
    eb.push_back(8'h41); eb.push_back(8'h42); eb.push_back(8'h43);
    check_bytes("t1_bytes", eb);

    // round-robin order with 1-byte packets
    do_reset();
    for (int k = 0; k < N; k++) add_pkt(k, 1, 1'b1, 8'h10 * k);
    add_pkt(0, 1, 1'b1, 8'h99);
    repeat (18) step();
    eg.delete();
    eg.push_back(0); eg.push_back(1); eg.push_back(2); eg.push_back(3); eg.push_back(0);
    check_grants("t2_order", eg);

    // backpressure mid-packet on req1
    do_reset();
    add_pkt(1, 6, 1'b1, 8'h20);
    repeat (3 + HDRS) step();
    full_pct = 100;
    repeat (5) step();
    full_pct = 0;
    repeat (10) step();
    eb.delete();
    if (HDRS == 1) eb.push_back(hdr_byte(1));
    for (int i = 0; i < 6; i++) eb.push_back(DW'(8'h20 + i));
    check_bytes("t3_bytes", eb);

    // forced release after MAX_BURST
    do_reset();
    add_pkt(2, 20, 1'b0, 8'h60);
    add_pkt(3, 2, 1'b1, 8'hA0);
    repeat (35) step();
    eg.delete();
    eg.push_back(2); eg.push_back(3); eg.push_back(2);
    check_grants("t4_order", eg);
    check_eq("t4_writes", 32'(wr_cnt), 32'(22 + 3 * HDRS));

    // reset mid-transfer, then arbitration restarts at req0
    do_reset();
    add_pkt(3, 5, 1'b1, 8'hC0);
    repeat (3) step();
    do_reset();
    for (int k = 0; k < N; k++) add_pkt(k, 1, 1'b1, 8'h30 + k);
    repeat (4) step();
    eg.delete();
    eg.push_back(0);
    check_grants("t5_first", eg);

`ifdef UART_TX_ARB_HDR_EN
    do_reset();
    add_pkt(1, 1, 1'b1, 8'h55);
    repeat (5) step();
    eb.delete();
    eb.push_back(8'h81); eb.push_back(8'h55);
    check_bytes("t6_hdr", eb);
`endif

    // random traffic with backpressure and a mid-run reset
    do_reset();
    valid_pct = 75; full_pct = 25;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc == 700) do_reset();
      if ($urandom_range(99) < 6)
        add_pkt($urandom_range(N-1), $urandom_range(24, 1), ($urandom_range(9) != 0),
                $urandom_range(255));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
